// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: slave end of the pipeline data bus, backed by a word-addressed
// 64-bit RAM with a fixed access latency.
//
// Parameters:
//   LATENCY - WAIT cycles before an access commits (1..15)
//   DEPTH   - RAM depth in 64-bit words (power of two)
//   BASE    - byte address of word 0
// Ports:
//   clk    - clock
//   resetn - asynchronous active-low reset
//   dreq   - request (valid, addr, size, strobe, lane-aligned data)
//   dresp  - response (addr_ok, data_ok, registered read data)
//
// A non-zero strobe makes the access a write; zero strobe is a full-word read.
// Out-of-range accesses still complete; writes are dropped and reads return zero.

package dbus_pkg;

  typedef enum logic [2:0] {
    MsizeB = 3'd0,
    MsizeH = 3'd1,
    MsizeW = 3'd2,
    MsizeD = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 1024,
  parameter logic [63:0] BASE    = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       resetn,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int unsigned Aw      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [Aw-1:0] idx_q, idx_d;
  logic          in_range_q, in_range_d;
  logic [7:0]    strb_q, strb_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          commit;

  logic [63:0]   mem [DEPTH];

  // Address decode of the incoming request; only the result is latched.
  logic [63:0] off;
  logic        req_in_range;
  logic        unused_req;

  assign off          = dreq.addr - BASE;
  assign req_in_range = (dreq.addr >= BASE) && ((off >> 3) < 64'(DEPTH));
  assign unused_req   = ^{dreq.size, off[2:0]};

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      in_range_q <= 1'b0;
      strb_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      in_range_q <= in_range_d;
      strb_q     <= strb_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    in_range_d = in_range_q;
    strb_d     = strb_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (dreq.valid) begin
          idx_d      = off[Aw+2:3];
          in_range_d = req_in_range;
          strb_d     = dreq.strobe;
          wdata_d    = dreq.data;
          cnt_d      = CntLoad;
          state_d    = StWait;
        end
      end
      StWait: begin
        // Abort takes priority over a commit due in the same cycle.
        if (!dreq.valid) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (commit) begin
      rdata_d = (strb_q == '0 && in_range_q) ? mem[idx_q] : '0;
    end
  end

  // Output logic
  always_comb begin
    dresp         = '0;
    dresp.addr_ok = (state_q == StResp);
    dresp.data_ok = (state_q == StResp);
    dresp.data    = rdata_q;
    commit        = (state_q == StWait) && dreq.valid && (cnt_q == '0);
  end

  // RAM is deliberately not reset; its contents survive resetn.
  always_ff @(posedge clk) begin
    if (commit && in_range_q) begin
      for (int i = 0; i < 8; i++) begin
        if (strb_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule
